// File: rtl/cp0_commit_pkg.sv
// Shared CP0 constants: exception codes, register numbers, SR/Cause field positions
// and the NORMAL/HANDLER pipeline state.
package cp0_commit_pkg;
    localparam logic [31:0] PRID    = 32'h0000_4850;
    localparam logic [31:0] EXC_VEC = 32'h0000_4180;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    localparam int SR_IE     = 0;
    localparam int SR_EXL    = 1;
    localparam int SR_IM_LO  = 10;
    localparam int CAUSE_BD  = 31;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_EXC_LO = 2;

    typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} pstate_e;
endpackage

// File: rtl/cp0_commit.sv
// M-stage CP0 commit: take/eret decision plus SR, Cause, EPC, PRId storage and mfc0 mux.
// Optional BadVAddr register (reg 8) enabled by defining CP0_BADVADDR_EN.
module cp0_commit
    import cp0_commit_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_m,
    input  logic [31:0] pc_m,
    input  logic [4:0]  exccode_m,
    input  logic        bd_m,
    input  logic [31:0] ao_m,
    input  logic [5:0]  hwint,
    input  logic        we,
    input  logic        eret_m,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        take,
    output logic [31:0] target,
    output logic [31:0] epc_out
);
    pstate_e     state_q, state_d;
    logic [5:0]  im_q, im_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic        exl, int_pend, exc_pend, do_eret, do_wr;
    logic [4:0]  code;

    // EXL is exactly the HANDLER state; it masks every new take.
    assign exl      = (state_q == HANDLER);
    assign int_pend = valid_m & (|(hwint & im_q)) & ie_q & ~exl;
    assign exc_pend = valid_m & (exccode_m != 5'd0) & ~exl;
    assign take     = int_pend | exc_pend;
    assign code     = int_pend ? EXC_INT : exccode_m;
    assign do_eret  = valid_m & eret_m & ~take;
    assign do_wr    = valid_m & we & ~take;
    assign target   = take ? EXC_VEC : (do_eret ? epc_q : 32'd0);
    assign epc_out  = epc_q;

    always_comb begin
        state_d = state_q;
        im_d    = im_q;
        ie_d    = ie_q;
        bd_d    = bd_q;
        exc_d   = exc_q;
        epc_d   = epc_q;
        if (take) begin
            state_d = HANDLER;
            bd_d    = bd_m;
            exc_d   = code;
            epc_d   = bd_m ? pc_m - 32'd4 : pc_m;
        end else begin
            if (do_wr && addr == REG_SR) begin
                im_d    = din[SR_IM_LO +: 6];
                ie_d    = din[SR_IE];
                state_d = din[SR_EXL] ? HANDLER : NORMAL;
            end
            if (do_wr && addr == REG_EPC)
                epc_d = {din[31:2], 2'b00};
            // eret applied after an SR write so a same-cycle eret always leaves EXL clear
            if (do_eret)
                state_d = NORMAL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= NORMAL;
            im_q    <= '0;
            ie_q    <= 1'b0;
            bd_q    <= 1'b0;
            ip_q    <= '0;
            exc_q   <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            im_q    <= im_d;
            ie_q    <= ie_d;
            bd_q    <= bd_d;
            ip_q    <= hwint;
            exc_q   <= exc_d;
            epc_q   <= epc_d;
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_q, badvaddr_d;

    always_comb begin
        badvaddr_d = badvaddr_q;
        if (take && (code == EXC_ADEL || code == EXC_ADES))
            badvaddr_d = ao_m;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) badvaddr_q <= '0;
        else          badvaddr_q <= badvaddr_d;
    end
`else
    logic [31:0] badvaddr_q;
    logic        unused_ao;
    assign badvaddr_q = 32'd0;
    assign unused_ao  = ^ao_m;
`endif

    always_comb begin
        dout = 32'd0;
        case (addr)
            REG_BADVADDR: dout = badvaddr_q;
            REG_SR:       dout = {16'd0, im_q, 8'd0, exl, ie_q};
            REG_CAUSE:    dout = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};
            REG_EPC:      dout = epc_q;
            REG_PRID:     dout = PRID;
            default:      dout = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_cp0_commit.sv
// Self-checking bench for cp0_commit: directed vector table, async-reset sequence,
// then randomized cycles against a field-level reference model.
module tb_cp0_commit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_m, bd_m, we, eret_m;
    logic [31:0] pc_m, ao_m, din;
    logic [4:0]  exccode_m, addr;
    logic [5:0]  hwint;
    logic [31:0] dout, target, epc_out;
    logic        take;

    cp0_commit dut (
        .clk(clk), .reset_n(reset_n), .valid_m(valid_m), .pc_m(pc_m),
        .exccode_m(exccode_m), .bd_m(bd_m), .ao_m(ao_m), .hwint(hwint),
        .we(we), .eret_m(eret_m), .addr(addr), .din(din),
        .dout(dout), .take(take), .target(target), .epc_out(epc_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef CP0_BADVADDR_EN
    localparam logic [31:0] BVA_EXP = 32'hBAD0_0001;
`else
    localparam logic [31:0] BVA_EXP = 32'h0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model state, one variable per architectural field
    logic [5:0]  m_im, m_ip;
    logic        m_ie, m_exl, m_bd;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_bva;

    task automatic m_reset();
        m_im = 0; m_ip = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_exc = 0; m_epc = 0; m_bva = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
`ifdef CP0_BADVADDR_EN
            5'd8:  return m_bva;
`endif
            5'd12: return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
            5'd13: return (32'(m_bd) << 31) | (32'(m_ip) << 10) | (32'(m_exc) << 2);
            5'd14: return m_epc;
            5'd15: return 32'h0000_4850;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_int();
        return valid_m && ((hwint & m_im) != 0) && m_ie && !m_exl;
    endfunction

    function automatic logic m_take();
        return m_int() || (valid_m && exccode_m != 0 && !m_exl);
    endfunction

    function automatic logic [31:0] m_target();
        if (m_take()) return 32'h0000_4180;
        if (valid_m && eret_m) return m_epc;
        return 32'h0;
    endfunction

    task automatic m_clock();
        logic [4:0] c;
        if (m_take()) begin
            c = m_int() ? 5'd0 : exccode_m;
            m_exl = 1; m_bd = bd_m; m_exc = c;
            m_epc = bd_m ? pc_m - 32'd4 : pc_m;
            if (c == 5'd4 || c == 5'd5) m_bva = ao_m;
        end else if (valid_m) begin
            if (we && addr == 5'd12) begin
                m_im = din[15:10]; m_exl = din[1]; m_ie = din[0];
            end
            if (we && addr == 5'd14) m_epc = din & ~32'd3;
            if (eret_m) m_exl = 0;
        end
        m_ip = hwint;
    endtask

    typedef struct {
        logic v; logic [31:0] pc; logic [4:0] exc; logic bd; logic [31:0] ao;
        logic [5:0] hw; logic we; logic er; logic [4:0] ad; logic [31:0] din;
        logic etake; logic [31:0] etgt; logic [31:0] edout; logic [31:0] eepc;
    } vec_t;
    vec_t tbl [19];

    task automatic drive_idle();
        valid_m = 0; pc_m = 0; exccode_m = 0; bd_m = 0; ao_m = 0;
        hwint = 0; we = 0; eret_m = 0; addr = 0; din = 0;
    endtask

    initial begin
        //          v  pc          exc bd ao            hw  we er ad  din            take tgt         dout           epc
        tbl[0]  = '{0, 32'h0,    0, 0, 32'h0,        0, 0, 0, 15, 32'h0,          0, 32'h0,    32'h4850,      32'h0};
        tbl[1]  = '{0, 32'h0,    0, 0, 32'h0,        0, 0, 0, 12, 32'h0,          0, 32'h0,    32'h0,         32'h0};
        tbl[2]  = '{1, 32'h3000, 0, 0, 32'h0,        0, 1, 0, 12, 32'h401,        0, 32'h0,    32'h0,         32'h0};
        tbl[3]  = '{1, 32'h3008, 0, 0, 32'h0,        1, 0, 0, 12, 32'h0,          1, 32'h4180, 32'h401,       32'h0};
        tbl[4]  = '{1, 32'h300C, 12,0, 32'h0,        0, 0, 0, 13, 32'h0,          0, 32'h0,    32'h400,       32'h3008};
        tbl[5]  = '{1, 32'h4180, 0, 0, 32'h0,        0, 0, 1, 12, 32'h0,          0, 32'h3008, 32'h403,       32'h3008};
        tbl[6]  = '{1, 32'h3010, 4, 1, 32'hBAD00001, 0, 0, 0, 12, 32'h0,          1, 32'h4180, 32'h401,       32'h3008};
        tbl[7]  = '{0, 32'h0,    0, 0, 32'h0,        0, 0, 0, 13, 32'h0,          0, 32'h0,    32'h8000_0010, 32'h300C};
        tbl[8]  = '{1, 32'h4184, 0, 0, 32'h0,        0, 0, 1, 14, 32'h0,          0, 32'h300C, 32'h300C,      32'h300C};
        tbl[9]  = '{0, 32'h0,    0, 0, 32'h0,        1, 0, 0, 12, 32'h0,          0, 32'h0,    32'h401,       32'h300C};
        tbl[10] = '{1, 32'h3020, 0, 0, 32'h0,        1, 0, 0, 13, 32'h0,          1, 32'h4180, 32'h8000_0410, 32'h300C};
        tbl[11] = '{1, 32'h4188, 0, 0, 32'h0,        0, 0, 1, 14, 32'h0,          0, 32'h3020, 32'h3020,      32'h3020};
        tbl[12] = '{1, 32'h3030, 10,0, 32'h0,        0, 1, 0, 14, 32'h1234_5677,  1, 32'h4180, 32'h3020,      32'h3020};
        tbl[13] = '{1, 32'h418C, 0, 0, 32'h0,        0, 0, 1, 13, 32'h0,          0, 32'h3030, 32'h28,        32'h3030};
        tbl[14] = '{1, 32'h3034, 0, 0, 32'h0,        0, 1, 0, 14, 32'h1234_5677,  0, 32'h0,    32'h3030,      32'h3030};
        tbl[15] = '{0, 32'h0,    0, 0, 32'h0,        0, 0, 0, 14, 32'h0,          0, 32'h0,    32'h1234_5674, 32'h1234_5674};
        tbl[16] = '{0, 32'h0,    0, 0, 32'h0,        0, 0, 0, 8,  32'h0,          0, 32'h0,    BVA_EXP,       32'h1234_5674};
        tbl[17] = '{1, 32'h3038, 0, 0, 32'h0,        0, 1, 0, 13, 32'hFFFF_FFFF,  0, 32'h0,    32'h28,        32'h1234_5674};
        tbl[18] = '{0, 32'h0,    0, 0, 32'h0,        0, 0, 0, 13, 32'h0,          0, 32'h0,    32'h28,        32'h1234_5674};

        drive_idle();
        reset_n = 0;
        #12;
        @(negedge clk);
        reset_n = 1;

        for (int i = 0; i < 19; i++) begin
            valid_m = tbl[i].v; pc_m = tbl[i].pc; exccode_m = tbl[i].exc; bd_m = tbl[i].bd;
            ao_m = tbl[i].ao; hwint = tbl[i].hw; we = tbl[i].we; eret_m = tbl[i].er;
            addr = tbl[i].ad; din = tbl[i].din;
            #2;
            chk($sformatf("vec%0d take", i), 32'(take), 32'(tbl[i].etake));
            chk($sformatf("vec%0d target", i), target, tbl[i].etgt);
            chk($sformatf("vec%0d dout", i), dout, tbl[i].edout);
            chk($sformatf("vec%0d epc_out", i), epc_out, tbl[i].eepc);
            @(negedge clk);
        end

        // enter the handler, then pull reset between edges: EXL must clear immediately
        drive_idle();
        valid_m = 1; hwint = 6'b000001; pc_m = 32'h4000;
        #2;
        chk("async take", 32'(take), 32'd1);
        @(negedge clk);
        drive_idle();
        addr = 5'd12;
        #2;
        chk("async pre sr", dout, 32'h403);
        reset_n = 0;
        #1;
        chk("async sr cleared", dout, 32'h0);
        chk("async epc cleared", epc_out, 32'h0);
        @(negedge clk);
        reset_n = 1;
        m_reset();

        for (int n = 0; n < 600; n++) begin
            int r;
            logic [4:0] codes [7];
            codes = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
            valid_m   = ($urandom_range(0, 5) != 0);
            pc_m      = $urandom() & ~32'd3;
            exccode_m = codes[$urandom_range(0, 6)];
            bd_m      = $urandom_range(0, 1) == 1;
            ao_m      = $urandom();
            hwint     = ($urandom_range(0, 3) == 0) ? 6'($urandom()) : 6'd0;
            we        = ($urandom_range(0, 4) == 0);
            eret_m    = ($urandom_range(0, 3) == 0);
            r         = $urandom_range(0, 5);
            addr      = (r == 0) ? 5'd8 : (r == 1) ? 5'd12 : (r == 2) ? 5'd13 :
                        (r == 3) ? 5'd14 : (r == 4) ? 5'd15 : 5'($urandom());
            din       = (addr == 5'd12 && $urandom_range(0, 1) == 1) ?
                        ($urandom() & 32'hFFFF_FFFD) : $urandom();
            #2;
            chk("rnd take", 32'(take), 32'(m_take()));
            chk("rnd target", target, m_target());
            chk("rnd dout", dout, m_read(addr));
            chk("rnd epc_out", epc_out, m_epc);
            @(posedge clk);
            m_clock();
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cp0_commit.md
# cp0_commit

M-stage coprocessor-0 commit block for the five-stage MIPS pipeline. Consumes the per-instruction exception code and branch-delay flag produced by M-stage exception detection, merges them with six hardware interrupt lines, and decides each cycle whether to redirect to the handler. Holds SR, Cause, EPC and PRId, and services mfc0/mtc0/eret issued from M.

## Interface
- PRID, 32'h0000_4850, read-only value of PRId (reg 15)
- EXC_VEC, 32'h0000_4180, handler entry address driven on `target` during a take
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- valid_m  in  1  M slot holds a real instruction (0 = bubble)
- pc_m  in  32  PC of the M instruction
- exccode_m  in  5  synchronous exception code (0 = none, 4 AdEL, 5 AdES, 10 RI, 12 Ov)
- bd_m  in  1  M instruction sits in a branch delay slot
- ao_m  in  32  M-stage address (used only under CP0_BADVADDR_EN)
- hwint  in  6  external interrupt lines, level-sensitive
- we  in  1  mtc0 write enable
- eret_m  in  1  eret in M
- addr  in  5  CP0 register number
- din  in  32  mtc0 data
- dout  out  32  mfc0 read data, combinational
- take  out  1  flush pipeline and redirect this cycle
- target  out  32  redirect address (EXC_VEC on take, EPC on eret)
- epc_out  out  32  current EPC

## Operation
- SR: IM = bits 15:10, EXL = bit 1, IE = bit 0; other bits read 0. Cause: BD = 31, IP = 15:10, ExcCode = 6:2. EPC word-aligned (bits 1:0 forced 0 on write).
- int_pend = |(hwint & SR.IM) & SR.IE & !SR.EXL & valid_m.
- exc_pend = (exccode_m != 0) & !SR.EXL & valid_m.
- take = int_pend | exc_pend. Interrupt beats synchronous exception; recorded ExcCode = 0 for interrupt, else exccode_m.
- On take (next edge): EXL<=1; Cause.BD<=bd_m; Cause.ExcCode<=code; EPC<= bd_m ? pc_m-4 : pc_m (32-bit modular).
- eret_m (valid_m=1, no take): EXL<=0; target=EPC; take stays 0.
- Cause.IP<=hwint every cycle regardless of state.
- mtc0 (we & valid_m & !take) writes SR (12) or EPC (14); writes to Cause, PRId or unimplemented numbers are ignored.
- dout: SR, Cause, EPC, PRID for 12/13/14/15; 0 otherwise. Cause.IP reads the registered value.
- Bubble (valid_m=0): no take, no write, no eret; pending interrupt stays pending until the next valid slot.

## Timing
- Reset: SR, Cause, EPC all 0; take = 0, target = 0, dout = 0 for addresses other than 15.
- take/target combinational from current-cycle inputs and registers; register update at the same rising edge that the pipeline flushes.
- Take and mtc0 in same cycle: take wins, write dropped. Take and eret same cycle: take wins (EXL stays 1).
- While EXL=1: all interrupts and synchronous exceptions are masked (no nesting).
- reset_n asserted mid-handler clears EXL immediately and asynchronously.
- Pipeline state: NORMAL (EXL=0) -> HANDLER on take; HANDLER -> NORMAL on eret.

## Configuration
- CP0_BADVADDR_EN defined: adds BadVAddr (reg 8). It loads ao_m on a take with code 4 or 5, resets to 0, and is readable via mfc0. Without it, reg 8 reads 0 and ao_m is unused.

## Structure
- Shared package/header: exception codes (INT, ADEL, ADES, RI, OV), CP0 register numbers, SR/Cause bit positions.
- Single module. Optional sub-module `cp0_regfile` holds the register storage and read mux, leaving the take/eret decision in the top module.

## Test plan
- Reset, then mfc0 15 -> dout = 32'h0000_4850; mfc0 12 -> 0.
- SR = 32'h0000_0401, hwint = 6'b000001, valid_m, pc_m = 32'h3008 -> take = 1, target = 32'h4180; next cycle EPC = 32'h3008, Cause.ExcCode = 0, EXL = 1.
- exccode_m = 4, bd_m = 1, pc_m = 32'h3010 -> EPC = 32'h300C, Cause = 32'h8000_0010. With CP0_BADVADDR_EN, reg 8 = ao_m.
- EXL = 1, exccode_m = 12 -> take = 0. Then eret_m -> target = EPC, EXL cleared next cycle.
- Interrupt during bubble (valid_m = 0) -> take = 0; take = 1 on the following valid cycle, with that slot's pc_m saved.
- mtc0 14 with din = 32'h1234_5677 and simultaneous exccode_m = 10 -> EPC = pc_m, not din; a lone mtc0 14 with the same din -> EPC = 32'h1234_5674.
